dsm_interp_feeder: RTL and testbench

Sample-rate feeder that sits directly upstream of the first-order delta-sigma DAC modulator. It accepts signed PCM samples over a valid/ready handshake into a small FIFO. Each sample is expanded into 2^OSR_LOG2 oversampled words, linearly interpolated or zero-order held. Each word is presented with a one-cycle enable strobe that drives the modulator's data and enable inputs.

---
 rtl/dsm_interp_feeder.sv | 164 ++++++++++++++++
 tb/tb_dsm_interp_feeder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dsm_interp_feeder.sv
// Oversampling feeder for the first-order delta-sigma DAC modulator: input FIFO plus per-sample interpolation.
// Define DSM_FEEDER_INTERP_EN for linear interpolation; when undefined, each sample is held (zero-order hold).
module dsm_interp_feeder #(
  parameter int DATA_WIDTH      = 16,
  parameter int OSR_LOG2        = 6,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int CLK_DIV         = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_enable,
  input  logic                         i_valid,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic                         o_ready,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_en,
  output logic                         o_underrun,
  input  logic                         i_clr_underrun
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int SW    = DATA_WIDTH + 1;
  localparam int AW    = SW + OSR_LOG2;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL    = (FIFO_DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DIV_W-1:0]         DIV_TOP = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

  // Sample scaled into accumulator units (x * OSR), sign-extended to the full width.
  function automatic logic signed [AW-1:0] to_acc(input logic signed [DATA_WIDTH-1:0] x);
    return {x[DATA_WIDTH-1], x, {OSR_LOG2{1'b0}}};
  endfunction

  logic signed [DATA_WIDTH-1:0] fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]     count;
  logic                         fifo_empty, wr, pop;
  logic signed [DATA_WIDTH-1:0] head;

  state_t                       state, state_nxt;
  logic signed [DATA_WIDTH-1:0] y1;
  logic signed [SW-1:0]         step;
  logic signed [AW-1:0]         acc, prime_acc, bnd_acc, step_ext;
  logic [OSR_LOG2-1:0]          k;
  logic [DIV_W-1:0]             div;
  logic                         active, div_hit, strobe, last_strobe, boundary;
  logic                         prime_pop, run_pop, ur_set;

  assign o_ready    = (count != FULL);
  assign fifo_empty = (count == '0);
  assign wr         = i_valid && o_ready;
  assign head       = fifo_mem[rd_ptr];
  assign pop        = prime_pop || run_pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (wr) begin
        fifo_mem[wr_ptr] <= i_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    prime_pop   = 1'b0;
    active      = (state == RUN) || (state == DRAIN);
    div_hit     = (div == DIV_TOP);
    strobe      = active && div_hit;
    last_strobe = strobe && (&k);
    boundary    = (state == RUN) && last_strobe;
    run_pop     = boundary && !fifo_empty;
    ur_set      = boundary && fifo_empty;
    case (state)
      IDLE:  if (i_enable) state_nxt = PRIME;
      PRIME: begin
        if (!i_enable) state_nxt = IDLE;
        else if (!fifo_empty) begin
          state_nxt = RUN;
          prime_pop = 1'b1;
        end
      end
      RUN:   if (!i_enable) state_nxt = DRAIN;
      DRAIN: if (last_strobe) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DSM_FEEDER_INTERP_EN
  logic signed [DATA_WIDTH-1:0] y0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       y0 <= '0;
    else if (prime_pop) y0 <= '0;
    else if (boundary)  y0 <= y1;
  end

  // Ramp starts at y0*OSR and climbs by (y1-y0) per strobe, so acc>>>OSR_LOG2 is the floor-interpolated value.
  assign step      = {y1[DATA_WIDTH-1], y1} - {y0[DATA_WIDTH-1], y0};
  assign prime_acc = '0;
  assign bnd_acc   = to_acc(y1);
`else
  assign step      = '0;
  assign prime_acc = to_acc(head);
  assign bnd_acc   = to_acc(run_pop ? head : y1);
`endif

  assign step_ext = {{OSR_LOG2{step[SW-1]}}, step};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      y1         <= '0;
      acc        <= '0;
      k          <= '0;
      div        <= '0;
      o_data     <= '0;
      o_en       <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_en <= strobe;
      if (ur_set)              o_underrun <= 1'b1;
      else if (i_clr_underrun) o_underrun <= 1'b0;

      if (prime_pop) begin
        y1  <= head;
        acc <= prime_acc;
        k   <= '0;
        div <= '0;
      end else if (active) begin
        div <= div_hit ? '0 : div + 1'b1;
        if (strobe) begin
          o_data <= acc[OSR_LOG2 +: DATA_WIDTH];
          if (boundary) begin
            // An empty FIFO keeps y1, so the next period holds the last sample.
            acc <= bnd_acc;
            k   <= '0;
            if (run_pop) y1 <= head;
          end else begin
            acc <= acc + step_ext;
            k   <= k + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dsm_interp_feeder.sv
// Scoreboard bench for dsm_interp_feeder (OSR=4, 4-entry FIFO, strobe every 3rd clock).
// Expected words come from a floor-division model of the interpolation (or hold) rule.
module tb_dsm_interp_feeder;
  localparam int DW   = 16;
  localparam int OSRL = 2;
  localparam int OSR  = 4;
  localparam int FDL  = 2;
  localparam int CDIV = 3;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic                 i_enable = 1'b0;
  logic                 i_valid = 1'b0;
  logic signed [DW-1:0] i_data = '0;
  logic                 i_clr_underrun = 1'b0;
  logic                 o_ready, o_en, o_underrun;
  logic signed [DW-1:0] o_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_cyc = 0;
  bit have_last = 1'b0;
  int exp_q[$];
  int samp[$];

  dsm_interp_feeder #(
    .DATA_WIDTH(DW), .OSR_LOG2(OSRL), .FIFO_DEPTH_LOG2(FDL), .CLK_DIV(CDIV)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_valid(i_valid),
    .i_data(i_data), .o_ready(o_ready), .o_data(o_data), .o_en(o_en),
    .o_underrun(o_underrun), .i_clr_underrun(i_clr_underrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floordiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q -= 1;
    return q;
  endfunction

  // One run from PRIME: ramp from 0 (or hold each sample), then one hold period of the last sample.
  task automatic build_exp();
    int prev;
    prev = 0;
    exp_q.delete();
    foreach (samp[i]) begin
      for (int j = 0; j < OSR; j++) begin
`ifdef DSM_FEEDER_INTERP_EN
        exp_q.push_back(prev + floordiv(j * (samp[i] - prev), OSR));
`else
        exp_q.push_back(samp[i]);
`endif
      end
      prev = samp[i];
    end
    for (int j = 0; j < OSR; j++) exp_q.push_back(prev);
  endtask

  // Advance one clock; sample on the falling edge and score any strobe.
  task automatic tick();
    int e;
    @(negedge i_clk);
    cyc++;
    if (i_rst_n && o_en) begin
      if (exp_q.size() == 0) chk("spurious_en", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("o_data", int'(o_data), e);
      end
      if (have_last) chk("strobe_gap", cyc - last_cyc, CDIV);
      have_last = 1'b1;
      last_cyc  = cyc;
    end
  endtask

  task automatic push(input int v);
    int g;
    g = 0;
    i_valid = 1'b1;
    i_data  = DW'(v);
    while (!o_ready && g < 100) begin
      tick();
      g++;
    end
    if (!o_ready) chk("push_timeout", 0, 1);
    else tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_size(input int target, input string tag);
    int g;
    g = 0;
    while (exp_q.size() > target && g < 2000) begin
      tick();
      g++;
    end
    if (exp_q.size() > target) chk(tag, exp_q.size(), target);
  endtask

  task automatic run_seq(input bit clr_hold, input bit keep_flag);
    int n, lat, acc_at;
    build_exp();
    n = samp.size();
    for (int i = 0; i < n && i < 4; i++) push(samp[i]);
    if (n >= 4) chk("full_ready", int'(o_ready), 0);
    if (n > 4) begin
      i_valid = 1'b1;
      i_data  = DW'(samp[4]);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("held_ready", int'(o_ready), 0);
      end
    end
    i_clr_underrun = clr_hold;
    have_last = 1'b0;
    i_enable  = 1'b1;
    lat = 0;
    acc_at = 0;
    while (!o_en && lat < 200) begin
      if (i_valid && o_ready && acc_at == 0) acc_at = lat + 1;
      tick();
      lat++;
      if (acc_at == lat) i_valid = 1'b0;
    end
    chk("first_en_latency", lat, CDIV + 2);
    if (n > 4) chk("fifth_accept_cycle", acc_at, 3);
    wait_size(OSR + 1, "wait_last_period");
    chk("underrun_early", int'(o_underrun), 0);
    wait_size(OSR, "wait_boundary");
    chk("underrun_set", int'(o_underrun), 1);
    if (clr_hold) begin
      tick();
      chk("underrun_clr_after_set", int'(o_underrun), 0);
      i_clr_underrun = 1'b0;
    end
    wait_size(OSR - 1, "wait_hold");
    i_enable = 1'b0;
    wait_size(0, "wait_drain");
    repeat (3 * OSR * CDIV) tick();
    chk("held_data", int'(o_data), samp[n-1]);
    if (!clr_hold && !keep_flag) begin
      chk("underrun_sticky", int'(o_underrun), 1);
      i_clr_underrun = 1'b1;
      tick();
      i_clr_underrun = 1'b0;
      chk("underrun_clr", int'(o_underrun), 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_o_data", int'(o_data), 0);
    chk("rst_o_en", int'(o_en), 0);
    chk("rst_o_ready", int'(o_ready), 1);
    chk("rst_o_underrun", int'(o_underrun), 0);
    i_rst_n = 1'b1;
    tick();

    samp = '{400, 800};
    run_seq(1'b0, 1'b0);
    samp = '{-3};
    run_seq(1'b1, 1'b0);
    samp = '{1, 2, 3, 4, 5};
    run_seq(1'b0, 1'b0);
    samp = '{32767, -32768, 32767};
    run_seq(1'b0, 1'b1);

    // Asynchronous reset in the middle of a run with a full FIFO and the flag set.
    samp = '{1000, 2000, 3000};
    build_exp();
    for (int i = 0; i < 3; i++) push(samp[i]);
    have_last = 1'b0;
    i_enable  = 1'b1;
    wait_size(exp_q.size() - 2, "wait_mid_run");
    push(4000);
    push(5000);
    chk("ready_full_run", int'(o_ready), 0);
    #3 i_rst_n = 1'b0;
    #1;
    chk("arst_o_data", int'(o_data), 0);
    chk("arst_o_en", int'(o_en), 0);
    chk("arst_o_ready", int'(o_ready), 1);
    chk("arst_o_underrun", int'(o_underrun), 0);
    exp_q.delete();
    tick();
    #2 i_rst_n = 1'b1;
    repeat (40) tick();
    chk("prime_no_underrun", int'(o_underrun), 0);
    chk("prime_ready", int'(o_ready), 1);
    i_enable = 1'b0;
    repeat (2) tick();

    samp = '{-8};
    run_seq(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
